// File: rtl/dispatch_stage_nw_if.sv
`default_nettype none
// ============================================================================
// Module      : dispatch_stage_nw_if
// Description : Rename-to-dispatch bus: instruction group, wakeup, retire and
//               registered RS/ROB dispatch outputs.
// Revision    : 1.0
// ============================================================================
interface dispatch_stage_nw_if #(
    parameter int WIDTH     = 2,
    parameter int ROB_DEPTH = 16,
    parameter int PREGS     = 64,
    parameter int NUM_ALU   = 2,
    parameter int WB_PORTS  = 2
);
    localparam int PW = $clog2(PREGS);
    localparam int RW = $clog2(ROB_DEPTH);
    localparam int FW = $clog2(NUM_ALU + 1);
    localparam int CW = $clog2(ROB_DEPTH + 1);
    localparam int NW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]       in_valid;
    logic                   in_ready;
    logic [WIDTH*PW-1:0]    in_rd;
    logic [WIDTH*PW-1:0]    in_rs1;
    logic [WIDTH*PW-1:0]    in_rs2;
    logic [WIDTH-1:0]       in_use_imm;
    logic [WIDTH-1:0]       in_mem;
    logic [WIDTH-1:0]       in_regwrite;
    logic [WB_PORTS-1:0]    wb_valid;
    logic [WB_PORTS*PW-1:0] wb_preg;
    logic [NW-1:0]          retire_cnt;
    logic [WIDTH-1:0]       out_valid;
    logic [WIDTH*RW-1:0]    out_rob_idx;
    logic [WIDTH*FW-1:0]    out_fu;
    logic [WIDTH-1:0]       out_src1rdy;
    logic [WIDTH-1:0]       out_src2rdy;
    logic [CW-1:0]          rob_count;

    modport master (
        output in_valid, in_rd, in_rs1, in_rs2, in_use_imm, in_mem, in_regwrite,
        output wb_valid, wb_preg, retire_cnt,
        input  in_ready, out_valid, out_rob_idx, out_fu, out_src1rdy, out_src2rdy,
        input  rob_count
    );

    modport slave (
        input  in_valid, in_rd, in_rs1, in_rs2, in_use_imm, in_mem, in_regwrite,
        input  wb_valid, wb_preg, retire_cnt,
        output in_ready, out_valid, out_rob_idx, out_fu, out_src1rdy, out_src2rdy,
        output rob_count
    );
endinterface
`default_nettype wire

// File: rtl/dispatch_stage_nw.sv
`default_nettype none
// ============================================================================
// Module      : dispatch_stage_nw
// Description : N-wide dispatch: ROB allocation, occupancy, preg ready table,
//               FU assignment. DISPATCH_FU_BALANCE_EN selects round-robin ALUs.
// Revision    : 1.0
// ============================================================================
module dispatch_stage_nw #(
    parameter int WIDTH     = 2,
    parameter int ROB_DEPTH = 16,
    parameter int PREGS     = 64,
    parameter int NUM_ALU   = 2,
    parameter int WB_PORTS  = 2
) (
    input  wire logic            clk,
    input  wire logic            reset,
    input  wire logic            flush,
    dispatch_stage_nw_if.slave   bus
);
    localparam int PW = $clog2(PREGS);
    localparam int RW = $clog2(ROB_DEPTH);
    localparam int FW = $clog2(NUM_ALU + 1);
    localparam int CW = $clog2(ROB_DEPTH + 1);
    localparam int NW = $clog2(WIDTH + 1);

    logic [RW-1:0]       tail_q, tail_d;
    logic [CW-1:0]       rob_count_q, rob_count_d;
    logic [PREGS-1:0]    ready_q, ready_d;
    logic [WIDTH-1:0]    out_valid_q, out_valid_d;
    logic [WIDTH*RW-1:0] out_rob_idx_q, out_rob_idx_d;
    logic [WIDTH*FW-1:0] out_fu_q, out_fu_d;
    logic [WIDTH-1:0]    out_src1rdy_q, out_src1rdy_d;
    logic [WIDTH-1:0]    out_src2rdy_q, out_src2rdy_d;

    logic [WIDTH-1:0]    take_w;
    logic [NW-1:0]       n_w;
    logic                in_ready_w;
    logic                accept_w;
    logic [WIDTH-1:0]    src1_rdy_w, src2_rdy_w;
    logic [WIDTH*FW-1:0] fu_w;
    logic [CW:0]         sum_w;
    logic [CW:0]         ret_w;

    // Only the packed prefix of in_valid counts; anything past the first hole is dropped.
    always_comb begin : c_take
        logic run;
        run    = 1'b1;
        take_w = '0;
        n_w    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            run       = run & bus.in_valid[i];
            take_w[i] = run;
            if (run) n_w = NW'(i + 1);
        end
    end

    assign in_ready_w = !flush && (rob_count_q <= CW'(ROB_DEPTH - WIDTH));
    assign accept_w   = in_ready_w && take_w[0];

    // Source readiness: table or same-cycle wakeup, killed by an older slot's write.
    always_comb begin : c_src
        logic [PW-1:0] p;
        logic          rdy;
        p          = '0;
        rdy        = 1'b0;
        src1_rdy_w = '0;
        src2_rdy_w = '0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int s = 0; s < 2; s++) begin
                p   = (s == 0) ? bus.in_rs1[i*PW +: PW] : bus.in_rs2[i*PW +: PW];
                rdy = ready_q[p];
                for (int w = 0; w < WB_PORTS; w++) begin
                    if (bus.wb_valid[w] && (bus.wb_preg[w*PW +: PW] == p)) rdy = 1'b1;
                end
                for (int j = 0; j < WIDTH; j++) begin
                    if ((j < i) && bus.in_regwrite[j] && (bus.in_rd[j*PW +: PW] == p)) rdy = 1'b0;
                end
                if (p == '0) rdy = 1'b1;
                if (s == 0) src1_rdy_w[i] = rdy;
                else        src2_rdy_w[i] = rdy | bus.in_use_imm[i];
            end
        end
    end

`ifdef DISPATCH_FU_BALANCE_EN
    logic [FW-1:0] rr_ptr_q, rr_ptr_d;

    always_comb begin : c_fu
        logic [FW-1:0] alu_ptr;
        alu_ptr = rr_ptr_q;
        fu_w    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (bus.in_mem[i]) begin
                fu_w[i*FW +: FW] = FW'(NUM_ALU);
            end else begin
                fu_w[i*FW +: FW] = alu_ptr;
                if (take_w[i]) alu_ptr = (alu_ptr == FW'(NUM_ALU - 1)) ? '0 : alu_ptr + FW'(1);
            end
        end
        rr_ptr_d = flush ? '0 : (accept_w ? alu_ptr : rr_ptr_q);
    end

    always_ff @(posedge clk) begin
        if (reset) rr_ptr_q <= '0;
        else       rr_ptr_q <= rr_ptr_d;
    end
`else
    always_comb begin : c_fu
        fu_w = '0;
        for (int i = 0; i < WIDTH; i++) begin
            fu_w[i*FW +: FW] = bus.in_mem[i] ? FW'(NUM_ALU) : FW'(i % NUM_ALU);
        end
    end
`endif

    always_comb begin : c_next
        sum_w         = {1'b0, rob_count_q} + (accept_w ? (CW+1)'(n_w) : '0);
        ret_w         = (CW+1)'(bus.retire_cnt);
        rob_count_d   = (ret_w > sum_w) ? '0 : CW'(sum_w - ret_w);
        tail_d        = tail_q;
        ready_d       = ready_q;
        out_valid_d   = '0;
        out_rob_idx_d = out_rob_idx_q;
        out_fu_d      = out_fu_q;
        out_src1rdy_d = out_src1rdy_q;
        out_src2rdy_d = out_src2rdy_q;

        for (int w = 0; w < WB_PORTS; w++) begin
            if (bus.wb_valid[w]) ready_d[bus.wb_preg[w*PW +: PW]] = 1'b1;
        end
        // Clears are applied after wakeups so a same-cycle clear wins.
        if (accept_w) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (take_w[i] && bus.in_regwrite[i] && (bus.in_rd[i*PW +: PW] != '0))
                    ready_d[bus.in_rd[i*PW +: PW]] = 1'b0;
                out_rob_idx_d[i*RW +: RW] = tail_q + RW'(i);
            end
            tail_d        = tail_q + RW'(n_w);
            out_valid_d   = take_w;
            out_fu_d      = fu_w;
            out_src1rdy_d = src1_rdy_w;
            out_src2rdy_d = src2_rdy_w;
        end
        ready_d[0] = 1'b1;

        if (flush) begin
            tail_d        = '0;
            rob_count_d   = '0;
            ready_d       = '1;
            out_rob_idx_d = '0;
            out_fu_d      = '0;
            out_src1rdy_d = '0;
            out_src2rdy_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tail_q        <= '0;
            rob_count_q   <= '0;
            ready_q       <= '1;
            out_valid_q   <= '0;
            out_rob_idx_q <= '0;
            out_fu_q      <= '0;
            out_src1rdy_q <= '0;
            out_src2rdy_q <= '0;
        end else begin
            tail_q        <= tail_d;
            rob_count_q   <= rob_count_d;
            ready_q       <= ready_d;
            out_valid_q   <= out_valid_d;
            out_rob_idx_q <= out_rob_idx_d;
            out_fu_q      <= out_fu_d;
            out_src1rdy_q <= out_src1rdy_d;
            out_src2rdy_q <= out_src2rdy_d;
        end
    end

    // Retiring more entries than are occupied is a protocol error upstream.
    always_ff @(posedge clk) begin
        if (!reset && !flush) begin
            assert ((CW+1)'(bus.retire_cnt) <= {1'b0, rob_count_q});
        end
    end

    assign bus.in_ready    = in_ready_w;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_rob_idx = out_rob_idx_q;
    assign bus.out_fu      = out_fu_q;
    assign bus.out_src1rdy = out_src1rdy_q;
    assign bus.out_src2rdy = out_src2rdy_q;
    assign bus.rob_count   = rob_count_q;
endmodule
`default_nettype wire

// File: tb/tb_dispatch_stage_nw.sv
`default_nettype none
// ============================================================================
// Module      : tb_dispatch_stage_nw
// Description : Directed table, corner sequences and random traffic against a
//               behavioural model of dispatch_stage_nw.
// Revision    : 1.0
// ============================================================================
module tb_dispatch_stage_nw;
    localparam int WIDTH = 2, ROB_DEPTH = 16, PREGS = 64, NUM_ALU = 2, WB_PORTS = 2;
    localparam int PW = $clog2(PREGS);
    localparam int RW = $clog2(ROB_DEPTH);
    localparam int FW = $clog2(NUM_ALU + 1);
    localparam int NW = $clog2(WIDTH + 1);

    logic clk = 1'b0;
    logic reset;
    logic flush;
    always #5 clk = ~clk;

    dispatch_stage_nw_if #(.WIDTH(WIDTH), .ROB_DEPTH(ROB_DEPTH), .PREGS(PREGS),
                           .NUM_ALU(NUM_ALU), .WB_PORTS(WB_PORTS)) bus ();

    dispatch_stage_nw #(.WIDTH(WIDTH), .ROB_DEPTH(ROB_DEPTH), .PREGS(PREGS),
                        .NUM_ALU(NUM_ALU), .WB_PORTS(WB_PORTS)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // stimulus for the current cycle
    bit [WIDTH-1:0]    t_v, t_imm, t_mem, t_rw;
    int                t_rd [WIDTH];
    int                t_rs1[WIDTH];
    int                t_rs2[WIDTH];
    bit [WB_PORTS-1:0] t_wbv;
    int                t_wbp[WB_PORTS];
    int                t_ret;
    bit                t_flush;

    // reference model state and predicted outputs
    bit             m_ready[PREGS];
    int             m_tail, m_count, m_rr;
    bit [WIDTH-1:0] e_valid;
    int             e_idx[WIDTH];
    int             e_fu [WIDTH];
    bit             e_s1 [WIDTH];
    bit             e_s2 [WIDTH];

    typedef struct {
        bit [1:0] v;
        int       rd0, rd1, rs1_0, rs1_1, rs2_0, rs2_1;
        bit [1:0] imm, rw, wbv;
        int       wbp0, wbp1, ret;
        bit       fl;
        bit [1:0] ev;
        int       eidx;
        bit [1:0] es1, es2;
        int       ecnt;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic clear_stim();
        t_v = '0; t_imm = '0; t_mem = '0; t_rw = '0; t_wbv = '0; t_ret = 0; t_flush = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin t_rd[i] = 0; t_rs1[i] = 0; t_rs2[i] = 0; end
        for (int w = 0; w < WB_PORTS; w++) t_wbp[w] = 0;
    endtask

    task automatic drive();
        logic [WIDTH*PW-1:0]    rd, r1, r2;
        logic [WB_PORTS*PW-1:0] wp;
        for (int i = 0; i < WIDTH; i++) begin
            rd[i*PW +: PW] = PW'(t_rd[i]);
            r1[i*PW +: PW] = PW'(t_rs1[i]);
            r2[i*PW +: PW] = PW'(t_rs2[i]);
        end
        for (int w = 0; w < WB_PORTS; w++) wp[w*PW +: PW] = PW'(t_wbp[w]);
        bus.in_valid = t_v;  bus.in_rd = rd;  bus.in_rs1 = r1;  bus.in_rs2 = r2;
        bus.in_use_imm = t_imm;  bus.in_mem = t_mem;  bus.in_regwrite = t_rw;
        bus.wb_valid = t_wbv;  bus.wb_preg = wp;  bus.retire_cnt = NW'(t_ret);
        flush = t_flush;
    endtask

    function automatic bit src_ok(input int p, input int slot);
        bit r;
        if (p == 0) return 1'b1;
        for (int j = 0; j < slot; j++)
            if (t_rw[j] && t_rd[j] == p) return 1'b0;
        r = m_ready[p];
        for (int w = 0; w < WB_PORTS; w++)
            if (t_wbv[w] && t_wbp[w] == p) r = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m_tail = 0; m_count = 0; m_rr = 0; e_valid = '0;
        for (int p = 0; p < PREGS; p++) m_ready[p] = 1'b1;
    endtask

    // One clock: predict from the rules, advance, then compare the registered outputs.
    task automatic cycle();
        int n, k;
        bit exp_rdy, acc;
        drive();
        #1;
        exp_rdy = !t_flush && (ROB_DEPTH - m_count >= WIDTH);
        chk("in_ready", int'(bus.in_ready), int'(exp_rdy));
        n = 0;
        while (n < WIDTH && t_v[n]) n++;
        acc = exp_rdy && (n > 0);
        e_valid = '0;
        if (t_flush) begin
            model_reset();
        end else begin
            if (acc) begin
                k = 0;
                for (int i = 0; i < n; i++) begin
                    e_valid[i] = 1'b1;
                    e_idx[i]   = (m_tail + i) % ROB_DEPTH;
                    e_s1[i]    = src_ok(t_rs1[i], i);
                    e_s2[i]    = t_imm[i] || src_ok(t_rs2[i], i);
                    if (t_mem[i]) e_fu[i] = NUM_ALU;
                    else begin
`ifdef DISPATCH_FU_BALANCE_EN
                        e_fu[i] = (m_rr + k) % NUM_ALU;
`else
                        e_fu[i] = i % NUM_ALU;
`endif
                        k++;
                    end
                end
                m_tail = (m_tail + n) % ROB_DEPTH;
                m_rr   = (m_rr + k) % NUM_ALU;
            end
            m_count = m_count + (acc ? n : 0) - t_ret;
            if (m_count < 0) m_count = 0;
            for (int w = 0; w < WB_PORTS; w++) if (t_wbv[w]) m_ready[t_wbp[w]] = 1'b1;
            if (acc)
                for (int i = 0; i < n; i++)
                    if (t_rw[i] && t_rd[i] != 0) m_ready[t_rd[i]] = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("out_valid", int'(bus.out_valid), int'(e_valid));
        chk("rob_count", int'(bus.rob_count), m_count);
        for (int i = 0; i < WIDTH; i++) begin
            if (e_valid[i]) begin
                chk($sformatf("rob_idx[%0d]", i), int'(bus.out_rob_idx[i*RW +: RW]), e_idx[i]);
                chk($sformatf("fu[%0d]", i), int'(bus.out_fu[i*FW +: FW]), e_fu[i]);
                chk($sformatf("src1rdy[%0d]", i), int'(bus.out_src1rdy[i]), int'(e_s1[i]));
                chk($sformatf("src2rdy[%0d]", i), int'(bus.out_src2rdy[i]), int'(e_s2[i]));
            end
        end
    endtask

    initial begin
        // v, rd0,rd1, rs1_0,rs1_1, rs2_0,rs2_1, imm, rw, wbv, wbp0,wbp1, ret, fl | ev, eidx, es1, es2, ecnt
        tbl[0] = '{2'b11, 5, 6, 1, 2, 3, 4, 2'b00, 2'b11, 2'b00, 0, 0, 0, 1'b0, 2'b11, 0, 2'b11, 2'b11, 2};
        tbl[1] = '{2'b11, 7, 8, 5, 7, 0, 6, 2'b00, 2'b11, 2'b00, 0, 0, 0, 1'b0, 2'b11, 2, 2'b00, 2'b01, 4};
        tbl[2] = '{2'b01, 9, 0, 5, 0, 6, 0, 2'b01, 2'b01, 2'b01, 5, 0, 0, 1'b0, 2'b01, 4, 2'b01, 2'b01, 5};
        tbl[3] = '{2'b01, 9, 0, 9, 0, 8, 0, 2'b00, 2'b01, 2'b10, 0, 9, 0, 1'b0, 2'b01, 5, 2'b01, 2'b00, 6};
        tbl[4] = '{2'b01, 0, 0, 9, 0, 5, 0, 2'b00, 2'b01, 2'b00, 0, 0, 2, 1'b0, 2'b01, 6, 2'b00, 2'b01, 5};
        tbl[5] = '{2'b10, 3, 3, 0, 0, 0, 0, 2'b00, 2'b11, 2'b00, 0, 0, 0, 1'b0, 2'b00, 0, 2'b00, 2'b00, 5};
        tbl[6] = '{2'b01, 0, 0, 3, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1'b0, 2'b01, 7, 2'b01, 2'b01, 6};
        tbl[7] = '{2'b11, 5, 5, 0, 0, 0, 0, 2'b00, 2'b11, 2'b00, 0, 0, 0, 1'b1, 2'b00, 0, 2'b00, 2'b00, 0};
        tbl[8] = '{2'b01, 0, 0, 9, 0, 8, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1'b0, 2'b01, 0, 2'b01, 2'b01, 1};

        clear_stim();
        reset = 1'b1;
        drive();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_rob_count", int'(bus.rob_count), 0);
        chk("rst_rob_idx", int'(bus.out_rob_idx), 0);
        chk("rst_fu", int'(bus.out_fu), 0);
        reset = 1'b0;
        model_reset();

        // directed vectors
        for (int v = 0; v < 9; v++) begin
            clear_stim();
            t_v = tbl[v].v;  t_imm = tbl[v].imm;  t_rw = tbl[v].rw;  t_wbv = tbl[v].wbv;
            t_rd[0] = tbl[v].rd0;   t_rd[1] = tbl[v].rd1;
            t_rs1[0] = tbl[v].rs1_0; t_rs1[1] = tbl[v].rs1_1;
            t_rs2[0] = tbl[v].rs2_0; t_rs2[1] = tbl[v].rs2_1;
            t_wbp[0] = tbl[v].wbp0;  t_wbp[1] = tbl[v].wbp1;
            t_ret = tbl[v].ret;  t_flush = tbl[v].fl;
            cycle();
            chk($sformatf("tbl%0d_valid", v), int'(bus.out_valid), int'(tbl[v].ev));
            chk($sformatf("tbl%0d_count", v), int'(bus.rob_count), tbl[v].ecnt);
            if (tbl[v].ev[0]) chk($sformatf("tbl%0d_idx0", v), int'(bus.out_rob_idx[RW-1:0]), tbl[v].eidx);
            if (tbl[v].ev[1]) chk($sformatf("tbl%0d_idx1", v), int'(bus.out_rob_idx[2*RW-1:RW]),
                                  (tbl[v].eidx + 1) % ROB_DEPTH);
            chk($sformatf("tbl%0d_s1", v), int'(bus.out_src1rdy & tbl[v].ev), int'(tbl[v].es1));
            chk($sformatf("tbl%0d_s2", v), int'(bus.out_src2rdy & tbl[v].ev), int'(tbl[v].es2));
        end

        // fill the ROB, hold a group while full, then retire and observe tail wrap
        clear_stim(); t_flush = 1'b1; cycle();
        clear_stim(); t_v = 2'b11;
        for (int g = 0; g < 8; g++) begin
            cycle();
            if (g == 6) chk("fill_count14", int'(bus.rob_count), 14);
        end
        chk("fill_idx_14_15", int'(bus.out_rob_idx), 8'hFE);
        chk("fill_count16", int'(bus.rob_count), 16);
        cycle();
        chk("held_valid", int'(bus.out_valid), 0);
        chk("held_ready", int'(bus.in_ready), 0);
        t_ret = 2; cycle();
        t_ret = 0; cycle();
        chk("wrap_valid", int'(bus.out_valid), 3);
        chk("wrap_idx_0_1", int'(bus.out_rob_idx), 8'h10);

        // FU assignment: all-ALU groups after a flush, then a mixed mem/ALU group
        clear_stim(); t_flush = 1'b1; cycle();
        clear_stim(); t_v = 2'b11;
        for (int g = 0; g < 3; g++) begin
            cycle();
            chk("fu_alu_pair", int'(bus.out_fu), 4'b0100);
        end
        t_mem = 2'b01; cycle();
`ifdef DISPATCH_FU_BALANCE_EN
        chk("fu_mixed", int'(bus.out_fu), 4'b0010);
`else
        chk("fu_mixed", int'(bus.out_fu), 4'b0110);
`endif

        // random traffic against the model
        for (int c = 0; c < 500; c++) begin
            clear_stim();
            t_v = WIDTH'($urandom_range(0, 3));
            t_imm = WIDTH'($urandom); t_mem = WIDTH'($urandom); t_rw = WIDTH'($urandom);
            t_wbv = WB_PORTS'($urandom);
            for (int i = 0; i < WIDTH; i++) begin
                t_rd[i] = $urandom_range(0, 15);
                t_rs1[i] = $urandom_range(0, 15);
                t_rs2[i] = $urandom_range(0, 15);
            end
            for (int w = 0; w < WB_PORTS; w++) t_wbp[w] = $urandom_range(0, 15);
            t_ret = $urandom_range(0, (m_count < WIDTH) ? m_count : WIDTH);
            t_flush = ($urandom_range(0, 59) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
